// File: rtl/lcd_pixel_unpacker_pkg.sv
// lcd_pixel_unpacker_pkg: shared widths, unpack phase encoding and RGB channel layout
// Contents:
//   PIXEL_W / WORD_W : pixel and packed FIFO word widths
//   phase_t          : unpack phase PH_0..PH_3 (wraps 3 -> 0)
//   pixel_t          : pixel with channel slices r=[23:16], g=[15:8], b=[7:0]
package lcd_pixel_unpacker_pkg;
    localparam int PIXEL_W = 24;
    localparam int WORD_W = 32;
    typedef enum logic [1:0] {PH_0, PH_1, PH_2, PH_3} phase_t;
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;
endpackage

// File: rtl/lcd_pixel_unpacker_if.sv
// lcd_pixel_unpacker_if: FIFO-side and LCD-side signals of the pixel unpacker
// Signals:
//   i_fifoData/i_fifoEmpty/o_fifoRead       : clock-crossing FIFO read port
//   o_pixelData/o_pixelValid/i_pixelReady   : pixel valid/ready stream to the LCD driver
//   o_frameDone/o_underflow                 : frame completion pulse, sticky starvation flag
// Modports: master = unpacker, slave = FIFO/LCD environment.
interface lcd_pixel_unpacker_if;
    import lcd_pixel_unpacker_pkg::*;
    logic [WORD_W-1:0] i_fifoData;
    logic i_fifoEmpty;
    logic o_fifoRead;
    logic [PIXEL_W-1:0] o_pixelData;
    logic o_pixelValid;
    logic i_pixelReady;
    logic o_frameDone;
    logic o_underflow;
    modport master (
        input i_fifoData, i_fifoEmpty, i_pixelReady,
        output o_fifoRead, o_pixelData, o_pixelValid, o_frameDone, o_underflow
    );
    modport slave (
        output i_fifoData, i_fifoEmpty, i_pixelReady,
        input o_fifoRead, o_pixelData, o_pixelValid, o_frameDone, o_underflow
    );
endinterface

// File: rtl/lcd_word_buffer.sv
// lcd_word_buffer: 2-entry buffer for FIFO read returns with in-flight read tracking
// Ports:
//   i_lcdClock, i_nReset : clock, synchronous active-low reset
//   i_fifoData           : FIFO data, valid the cycle after o_fifoRead
//   i_fifoEmpty          : FIFO empty flag
//   i_pop                : consume the head word this cycle
//   o_fifoRead           : FIFO read enable
//   o_word, o_wordValid  : head word and buffer-not-empty flag
module lcd_word_buffer
    import lcd_pixel_unpacker_pkg::*;
(
    input  logic              i_lcdClock,
    input  logic              i_nReset,
    input  logic [WORD_W-1:0] i_fifoData,
    input  logic              i_fifoEmpty,
    input  logic              i_pop,
    output logic              o_fifoRead,
    output logic [WORD_W-1:0] o_word,
    output logic              o_wordValid
);
    logic [WORD_W-1:0] mem [2];
    logic [1:0] count, occupancy;
    logic rdPtr, wrPtr, inFlight;
    // Occupancy already accounts for this cycle's pop, so a read can be
    // issued into the slot being freed; this keeps 1 pixel/clock sustainable.
    always_comb begin
        o_wordValid = count != 2'd0;
        o_word = mem[rdPtr];
        occupancy = count + {1'b0, inFlight} - {1'b0, i_pop};
        o_fifoRead = i_nReset && !i_fifoEmpty && occupancy < 2'd2;
    end
    always_ff @(posedge i_lcdClock) begin
        if (!i_nReset) begin
            count <= '0;
            rdPtr <= 1'b0;
            wrPtr <= 1'b0;
            inFlight <= 1'b0;
        end else begin
            inFlight <= o_fifoRead;
            count <= occupancy;
            if (inFlight) begin
                mem[wrPtr] <= i_fifoData;
                wrPtr <= !wrPtr;
            end
            if (i_pop) rdPtr <= !rdPtr;
        end
    end
endmodule

// File: rtl/lcd_pixel_unpacker.sv
// lcd_pixel_unpacker: unpacks 3 packed 32-bit FIFO words into 4 RGB pixels, one per clock
// Ports:
//   i_lcdClock, i_nReset : LCD pixel clock, synchronous active-low reset
//   bus (master)         : FIFO read port, pixel valid/ready stream, frame done, underflow
// Parameters:
//   FRAME_PIXELS : pixels per frame (multiple of 4)
//   CNT_W        : pixel counter width, 2**CNT_W > FRAME_PIXELS
module lcd_pixel_unpacker
    import lcd_pixel_unpacker_pkg::*;
#(
    parameter int FRAME_PIXELS = 384000,
    parameter int CNT_W = 19
) (
    input logic i_lcdClock,
    input logic i_nReset,
    lcd_pixel_unpacker_if.master bus
);
    logic [WORD_W-1:0] word;
    logic haveWord, pop, canLoad, step, xfer, lastPixel, frameActive;
    phase_t phase, phaseNext;
    logic [PIXEL_W-1:0] leftover, nextLeft;
    pixel_t nextPixel;
    logic [CNT_W-1:0] pixelCount;

    lcd_word_buffer wordBuffer (
        .i_lcdClock (i_lcdClock),
        .i_nReset   (i_nReset),
        .i_fifoData (bus.i_fifoData),
        .i_fifoEmpty(bus.i_fifoEmpty),
        .i_pop      (pop),
        .o_fifoRead (bus.o_fifoRead),
        .o_word     (word),
        .o_wordValid(haveWord)
    );

    always_ff @(posedge i_lcdClock) phase <= !i_nReset ? PH_0 : phaseNext;

    // Phase 3 drains the leftover register and never waits on the buffer.
    always_comb begin
        canLoad = !bus.o_pixelValid || bus.i_pixelReady;
        step = canLoad && (phase == PH_3 || haveWord);
        pop = step && phase != PH_3;
        phaseNext = step ? phase_t'(phase + 2'd1) : phase;
    end

    always_comb begin
        nextPixel = phase == PH_0 ? word[31:8] :
                    phase == PH_1 ? {leftover[7:0], word[31:16]} :
                    phase == PH_2 ? {leftover[15:0], word[31:24]} : leftover;
        nextLeft = phase == PH_0 ? {16'd0, word[7:0]} :
                   phase == PH_1 ? {8'd0, word[15:0]} :
                   phase == PH_2 ? word[23:0] : '0;
        xfer = bus.o_pixelValid && bus.i_pixelReady;
        lastPixel = pixelCount == CNT_W'(FRAME_PIXELS - 1);
    end

    always_ff @(posedge i_lcdClock) begin
        if (!i_nReset) begin
            bus.o_pixelData <= '0;
            bus.o_pixelValid <= 1'b0;
            bus.o_frameDone <= 1'b0;
            bus.o_underflow <= 1'b0;
            leftover <= '0;
            pixelCount <= '0;
            frameActive <= 1'b0;
        end else begin
            if (step) begin
                bus.o_pixelData <= nextPixel;
                leftover <= nextLeft;
            end
            if (canLoad) bus.o_pixelValid <= step;
            if (xfer) pixelCount <= lastPixel ? '0 : pixelCount + CNT_W'(1);
            frameActive <= xfer ? !lastPixel : frameActive;
            bus.o_frameDone <= xfer && lastPixel;
            bus.o_underflow <= bus.o_underflow || (frameActive && bus.i_pixelReady && !bus.o_pixelValid);
        end
    end
endmodule

// File: tb/tb_lcd_pixel_unpacker.sv
// tb_lcd_pixel_unpacker: scoreboard bench for the pixel unpacker (frame size 8)
module tb_lcd_pixel_unpacker;
    localparam int FP = 8;
    logic clk = 1'b0;
    logic nReset = 1'b0;
    logic fifoHold = 1'b0;
    int checks = 0, failures = 0;
    int pushed = 0, popped = 0, cyc = 0;
    int readCnt = 0, rdViol = 0, fdCnt = 0, fdCyc = 0, stableViol = 0;
    logic [31:0] words[$];
    logic [23:0] expQ[$], gotQ[$];
    int gotCyc[$];
    logic [63:0] acc = '0;
    int nbits = 0;
    logic prevStall = 1'b0;
    logic [23:0] prevData = '0;

    always #5 clk = ~clk;

    lcd_pixel_unpacker_if bus();
    lcd_pixel_unpacker #(.FRAME_PIXELS(FP), .CNT_W(4)) dut (
        .i_lcdClock(clk),
        .i_nReset  (nReset),
        .bus       (bus)
    );

    assign bus.i_fifoEmpty = (pushed == popped) || fifoHold;

    // FIFO model: read data appears the cycle after the read; reset flushes it.
    always @(posedge clk) begin
        if (!nReset) popped <= pushed;
        else if (bus.o_fifoRead && pushed != popped) begin
            bus.i_fifoData <= words[popped];
            popped <= popped + 1;
        end
    end

    always @(posedge clk) begin
        cyc++;
        if (nReset) begin
            if (bus.o_pixelValid && bus.i_pixelReady) begin
                gotQ.push_back(bus.o_pixelData);
                gotCyc.push_back(cyc);
            end
            if (bus.o_fifoRead) readCnt++;
            if (bus.o_fifoRead && bus.i_fifoEmpty) rdViol++;
            if (bus.o_frameDone) begin
                fdCnt++;
                fdCyc = cyc;
            end
            if (prevStall && (!bus.o_pixelValid || bus.o_pixelData !== prevData)) stableViol++;
            prevStall = bus.o_pixelValid && !bus.i_pixelReady;
            prevData = bus.o_pixelData;
        end else prevStall = 1'b0;
    end

    // Golden model: treat the word stream as one MSB-first bit stream cut into 24-bit pixels.
    task automatic pushWord(input logic [31:0] w);
        words.push_back(w);
        pushed++;
        acc = (acc << 32) | {32'd0, w};
        nbits += 32;
        while (nbits >= 24) begin
            expQ.push_back(24'(acc >> (nbits - 24)));
            nbits -= 24;
        end
    endtask

    task automatic clearSb();
        expQ.delete();
        gotQ.delete();
        gotCyc.delete();
        acc = '0;
        nbits = 0;
        readCnt = 0;
        rdViol = 0;
        fdCnt = 0;
        stableViol = 0;
    endtask

    task automatic doReset();
        @(negedge clk);
        nReset = 1'b0;
        bus.i_pixelReady = 1'b0;
        fifoHold = 1'b0;
        repeat (2) @(negedge clk);
        clearSb();
        nReset = 1'b1;
    endtask

    task automatic waitGot(input int n);
        int k = 0;
        while (gotQ.size() < n && k < 1000) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        nReset = 1'b0;
        bus.i_pixelReady = 1'b1;
        repeat (2) @(negedge clk);
        pushWord(32'h12345678);
        #1;
        checks++; if (bus.o_pixelData !== 24'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.o_pixelData); end
        checks++; if (bus.o_pixelValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.o_pixelValid); end
        checks++; if (bus.o_fifoRead !== 1'b0) begin failures++; $display("FAIL reset_read got=%b exp=0", bus.o_fifoRead); end
        checks++; if (bus.o_frameDone !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.o_frameDone); end
        checks++; if (bus.o_underflow !== 1'b0) begin failures++; $display("FAIL reset_uflow got=%b exp=0", bus.o_underflow); end
        doReset();
    endtask

    task automatic test_basic();
        int k = 0;
        doReset();
        bus.i_pixelReady = 1'b1;
        @(negedge clk);
        pushWord(32'hAABBCC11);
        pushWord(32'h2233DDEE);
        pushWord(32'hFF445566);
        while (bus.o_pixelValid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks++; if (k != 3) begin failures++; $display("FAIL basic_latency got=%0d exp=3", k); end
        waitGot(4);
        checks++; if (gotQ.size() != 4) begin failures++; $display("FAIL basic_count got=%0d exp=4", gotQ.size()); end
        else begin
            checks++; if (gotQ[0] !== 24'hAABBCC) begin failures++; $display("FAIL basic_px0 got=%h exp=aabbcc", gotQ[0]); end
            for (int i = 0; i < 4; i++) begin
                checks++; if (gotQ[i] !== expQ[i]) begin failures++; $display("FAIL basic_px%0d got=%h exp=%h", i, gotQ[i], expQ[i]); end
            end
            checks++; if (gotCyc[3] - gotCyc[0] != 3) begin failures++; $display("FAIL basic_consecutive got=%0d exp=3", gotCyc[3] - gotCyc[0]); end
        end
    endtask

    task automatic test_throughput();
        doReset();
        bus.i_pixelReady = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 12; i++) pushWord($urandom);
        waitGot(16);
        repeat (5) @(negedge clk);
        checks++; if (gotQ.size() != 16) begin failures++; $display("FAIL thru_count got=%0d exp=16", gotQ.size()); end
        else begin
            checks++; if (gotCyc[15] - gotCyc[0] != 15) begin failures++; $display("FAIL thru_span got=%0d exp=15", gotCyc[15] - gotCyc[0]); end
            for (int i = 0; i < 16; i++) begin
                checks++; if (gotQ[i] !== expQ[i]) begin failures++; $display("FAIL thru_px%0d got=%h exp=%h", i, gotQ[i], expQ[i]); end
            end
        end
        checks++; if (readCnt != 12) begin failures++; $display("FAIL thru_reads got=%0d exp=12", readCnt); end
    endtask

    task automatic test_backpressure();
        doReset();
        @(negedge clk);
        for (int i = 0; i < 6; i++) pushWord($urandom);
        repeat (10) @(negedge clk);
        checks++; if (readCnt != 3) begin failures++; $display("FAIL bp_reads got=%0d exp=3", readCnt); end
        checks++; if (bus.o_pixelValid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b exp=1", bus.o_pixelValid); end
        checks++; if (bus.o_pixelData !== expQ[0]) begin failures++; $display("FAIL bp_data got=%h exp=%h", bus.o_pixelData, expQ[0]); end
        bus.i_pixelReady = 1'b1;
        waitGot(8);
        checks++; if (gotQ.size() != 8) begin failures++; $display("FAIL bp_count got=%0d exp=8", gotQ.size()); end
        else for (int i = 0; i < 8; i++) begin
            checks++; if (gotQ[i] !== expQ[i]) begin failures++; $display("FAIL bp_px%0d got=%h exp=%h", i, gotQ[i], expQ[i]); end
        end
        checks++; if (stableViol != 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", stableViol); end
    endtask

    task automatic test_random();
        int n = 0, k = 0;
        doReset();
        while (n < 100 && k < 3000) begin
            @(negedge clk);
            k++;
            bus.i_pixelReady = 1'($urandom_range(0, 1));
            fifoHold = $urandom_range(0, 3) == 0;
            if ($urandom_range(0, 1) == 1) begin
                pushWord($urandom);
                n++;
            end
        end
        @(negedge clk);
        fifoHold = 1'b0;
        bus.i_pixelReady = 1'b1;
        waitGot(133);
        checks++; if (gotQ.size() != 133) begin failures++; $display("FAIL rand_count got=%0d exp=133", gotQ.size()); end
        else for (int i = 0; i < 133; i++) begin
            checks++; if (gotQ[i] !== expQ[i]) begin failures++; $display("FAIL rand_px%0d got=%h exp=%h", i, gotQ[i], expQ[i]); end
        end
        checks++; if (rdViol != 0) begin failures++; $display("FAIL rand_read_empty got=%0d exp=0", rdViol); end
        checks++; if (stableViol != 0) begin failures++; $display("FAIL rand_stable got=%0d exp=0", stableViol); end
    endtask

    task automatic test_frame();
        doReset();
        bus.i_pixelReady = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) pushWord($urandom);
        waitGot(8);
        repeat (3) @(negedge clk);
        checks++; if (fdCnt != 1) begin failures++; $display("FAIL frame_pulses got=%0d exp=1", fdCnt); end
        if (gotQ.size() == 8) begin
            checks++; if (fdCyc != gotCyc[7] + 1) begin failures++; $display("FAIL frame_when got=%0d exp=%0d", fdCyc, gotCyc[7] + 1); end
        end
        for (int i = 0; i < 3; i++) pushWord($urandom);
        waitGot(12);
        checks++; if (gotQ.size() != 12) begin failures++; $display("FAIL frame_count got=%0d exp=12", gotQ.size()); end
        else for (int i = 0; i < 12; i++) begin
            checks++; if (gotQ[i] !== expQ[i]) begin failures++; $display("FAIL frame_px%0d got=%h exp=%h", i, gotQ[i], expQ[i]); end
        end
        checks++; if (fdCnt != 1) begin failures++; $display("FAIL frame_midframe got=%0d exp=1", fdCnt); end
    endtask

    task automatic test_underflow();
        doReset();
        bus.i_pixelReady = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (bus.o_underflow !== 1'b0) begin failures++; $display("FAIL uflow_idle got=%b exp=0", bus.o_underflow); end
        pushWord(32'h01020304);
        waitGot(1);
        repeat (4) @(negedge clk);
        checks++; if (bus.o_underflow !== 1'b1) begin failures++; $display("FAIL uflow_set got=%b exp=1", bus.o_underflow); end
        pushWord(32'h05060708);
        pushWord(32'h090A0B0C);
        waitGot(4);
        repeat (2) @(negedge clk);
        checks++; if (bus.o_underflow !== 1'b1) begin failures++; $display("FAIL uflow_sticky got=%b exp=1", bus.o_underflow); end
        checks++; if (gotQ.size() != 4) begin failures++; $display("FAIL uflow_count got=%0d exp=4", gotQ.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++; if (gotQ[i] !== expQ[i]) begin failures++; $display("FAIL uflow_px%0d got=%h exp=%h", i, gotQ[i], expQ[i]); end
        end
    endtask

    task automatic test_reset_midflight();
        doReset();
        bus.i_pixelReady = 1'b1;
        @(negedge clk);
        pushWord(32'hDEADBEEF);
        pushWord(32'hCAFEF00D);
        waitGot(2);
        repeat (2) @(negedge clk);
        pushWord(32'h5A5A5A5A);
        #1;
        checks++; if (bus.o_fifoRead !== 1'b1) begin failures++; $display("FAIL mid_read got=%b exp=1", bus.o_fifoRead); end
        @(negedge clk);
        nReset = 1'b0;
        @(negedge clk);
        checks++; if (bus.o_pixelData !== 24'h0) begin failures++; $display("FAIL mid_data got=%h exp=0", bus.o_pixelData); end
        checks++; if (bus.o_pixelValid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", bus.o_pixelValid); end
        checks++; if (bus.o_fifoRead !== 1'b0) begin failures++; $display("FAIL mid_fread got=%b exp=0", bus.o_fifoRead); end
        checks++; if (bus.o_frameDone !== 1'b0) begin failures++; $display("FAIL mid_done got=%b exp=0", bus.o_frameDone); end
        checks++; if (bus.o_underflow !== 1'b0) begin failures++; $display("FAIL mid_uflow got=%b exp=0", bus.o_underflow); end
        clearSb();
        nReset = 1'b1;
        @(negedge clk);
        pushWord(32'h10203040);
        pushWord(32'h50607080);
        pushWord(32'h90A0B0C0);
        waitGot(4);
        checks++; if (gotQ.size() != 4) begin failures++; $display("FAIL mid_count got=%0d exp=4", gotQ.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++; if (gotQ[i] !== expQ[i]) begin failures++; $display("FAIL mid_px%0d got=%h exp=%h", i, gotQ[i], expQ[i]); end
        end
    endtask

    initial begin
        bus.i_pixelReady = 1'b0;
        bus.i_fifoData = '0;
        test_reset();
        test_basic();
        test_throughput();
        test_backpressure();
        test_random();
        test_frame();
        test_underflow();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end
endmodule
